serial_alu_seq: RTL and testbench
=================================

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have ports: in_a, in_b  input  WIDTH  parallel operands; in_op  input  2  op (00 ADD, 01 XOR, 10 AND, 11 OR).
REQ-007 SHALL have ports: alu_rs1, alu_rs2, alu_carry_in  output  1 each  bit stream to the external 1-bit ALU slice; alu_op  output  2  op to the slice.
REQ-008 SHALL have ports: alu_result, alu_carry_out  input  1 each  combinational return from the slice.
REQ-009 SHALL have ports: out_valid  output  1; out_ready  input  1  result handshake.
REQ-010 SHALL have ports: out_result  output  WIDTH; out_carry  output  1; out_zero  output  1; busy  output  1  (high in SHIFT or DONE).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-012 SHALL accept a request when in_valid & in_ready at a rising edge: latch in_a, in_b, in_op into shift/op registers, clear carry register, clear bit counter, go to SHIFT.
REQ-013 SHALL ignore in_valid in SHIFT and DONE; in_a/in_b/in_op changes after acceptance SHALL have no effect.
REQ-014 In SHIFT, SHALL drive alu_rs1 = a_shift[0], alu_rs2 = b_shift[0], alu_carry_in = carry register, alu_op = latched op (LSB-first serial order).
REQ-015 Each SHIFT edge SHALL shift a_shift and b_shift right by one, shift alu_result into the MSB of the result shift register, load carry register with alu_carry_out, increment counter.
REQ-016 SHALL stay in SHIFT for exactly WIDTH cycles; on the edge where counter == WIDTH-1, SHALL go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly WIDTH cycles after the accepting edge (WIDTH=8: accept at edge 0, out_valid high after edge 8).
REQ-018 On entering DONE, out_result SHALL equal the assembled WIDTH-bit result; out_carry SHALL equal final carry for op 00 and 0 otherwise; out_zero SHALL be 1 iff out_result == 0.
REQ-019 In DONE, out_valid SHALL be 1 and out_result/out_carry/out_zero SHALL be stable until out_valid & out_ready at an edge, then FSM SHALL go to IDLE.
REQ-020 out_result/out_carry/out_zero SHALL hold their last values in IDLE and SHIFT until the next DONE entry.
REQ-021 Outside SHIFT, alu_rs1, alu_rs2, alu_carry_in SHALL be 0 and alu_op SHALL be 00.
REQ-022 No new request SHALL be accepted in the same cycle as the result handshake; the earliest re-accept is the following cycle in IDLE.
REQ-023 Carry SHALL never propagate between operations; the carry register is cleared on every acceptance.
REQ-024 Counter width SHALL be clog2(WIDTH)+1 bits; no wrap-around within an operation.

Reset
REQ-025 While rst_n = 0, SHALL force state IDLE, counter 0, all shift/carry/op registers 0, out_valid 0, out_result 0, out_carry 0, out_zero 0, busy 0; in_ready SHALL be 1 once in IDLE.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately (asynchronously) with no out_valid pulse; first request after deassertion SHALL complete normally.

Verification
REQ-027 ADD 0x5A + 0x3C (WIDTH=8) -> out_result 0x96, out_carry 0, out_zero 0, out_valid exactly 8 cycles after accept.
REQ-028 ADD 0xFF + 0x01 -> out_result 0x00, out_carry 1, out_zero 1; next ADD 0x01 + 0x01 -> 0x02, out_carry 0.
REQ-029 XOR 0xAA ^ 0xAA -> 0x00, zero 1, carry 0; AND 0xF0 & 0x3C -> 0x30; OR 0xF0 | 0x0F -> 0xFF, carry 0.
REQ-030 Hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, outputs unchanged, in_ready 0, new request not taken; out_ready = 1 -> IDLE next cycle.
REQ-031 Assert rst_n = 0 after 3 SHIFT cycles of ADD 0x0F + 0x01 -> in_ready 1, busy 0, out_valid 0 during reset; after release, ADD 0x10 + 0x20 -> 0x30.
REQ-032 Monitor alu_* ports during ADD 0x03 + 0x01 -> rs1 bit sequence 1,1,0,0,0,0,0,0; carry_in sequence 0,1,1,0,0,0,0,0; all alu_* 0 in IDLE.

Source files
------------

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams WIDTH-bit operands LSB-first through an
// external 1-bit ALU slice and assembles the result, carry and zero flag.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             alu_rs1,
  output logic             alu_rs2,
  output logic             alu_carry_in,
  output logic [1:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-2:0] res_shift;
  logic             carry_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_next;

  // Result bits arrive LSB-first, so each new bit enters at the MSB.
  assign res_next = {alu_result, res_shift};

  // Slice drive registers are zero whenever the FSM is not in SHIFT.
  assign alu_rs1      = a_shift[0];
  assign alu_rs2      = b_shift[0];
  assign alu_carry_in = carry_q;
  assign alu_op       = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_shift    <= '0;
      b_shift    <= '0;
      res_shift  <= '0;
      carry_q    <= 1'b0;
      op_q       <= 2'b00;
      cnt        <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift  <= in_a;
            b_shift  <= in_b;
            op_q     <= in_op;
            carry_q  <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          a_shift   <= {1'b0, a_shift[WIDTH-1:1]};
          b_shift   <= {1'b0, b_shift[WIDTH-1:1]};
          res_shift <= res_next[WIDTH-1:1];
          carry_q   <= alu_carry_out;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // Final bit: publish the result and park the slice drives at zero.
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= res_next;
            out_carry  <= (op_q == OP_ADD) & alu_carry_out;
            out_zero   <= (res_next == '0);
            a_shift    <= '0;
            b_shift    <= '0;
            carry_q    <= 1'b0;
            op_q       <= 2'b00;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice and
// an expected-result queue filled on acceptance, drained on out_valid.
module tb_serial_alu_seq;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             alu_rs1;
  logic             alu_rs2;
  logic             alu_carry_in;
  logic [1:0]       alu_op;
  logic             alu_result;
  logic             alu_carry_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] rs1_seq;
  logic [WIDTH-1:0] rs2_seq;
  logic [WIDTH-1:0] cin_seq;
  int   latency;

  serial_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slice: carry-out is the full-adder majority for every op, so the DUT must mask it.
  always_comb begin
    alu_carry_out = (alu_rs1 & alu_rs2) | (alu_carry_in & (alu_rs1 ^ alu_rs2));
    case (alu_op)
      2'b00:   alu_result = alu_rs1 ^ alu_rs2 ^ alu_carry_in;
      2'b01:   alu_result = alu_rs1 ^ alu_rs2;
      2'b10:   alu_result = alu_rs1 & alu_rs2;
      default: alu_result = alu_rs1 | alu_rs2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] op);
    exp_t e;
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    e.carry = 1'b0;
    case (op)
      2'b00: begin e.result = sum[WIDTH-1:0]; e.carry = sum[WIDTH]; end
      2'b01: e.result = a ^ b;
      2'b10: e.result = a & b;
      default: e.result = a | b;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Present a request in IDLE and return just after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    in_op = 2'($urandom);
  endtask

  // Record the slice streams until out_valid (bounded), then compare with the queue head.
  task automatic wait_done();
    exp_t e;
    rs1_seq = '0; rs2_seq = '0; cin_seq = '0;
    latency = 0;
    while (!out_valid && latency < 20) begin
      if (latency < WIDTH) begin
        rs1_seq[latency] = alu_rs1;
        rs2_seq[latency] = alu_rs2;
        cin_seq[latency] = alu_carry_in;
      end
      @(posedge clk);
      #1;
      latency++;
    end
    check("latency", 32'(latency), 32'(WIDTH));
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_result", 32'(out_result), 32'(e.result));
      check("out_carry", 32'(out_carry), 32'(e.carry));
      check("out_zero", 32'(out_zero), 32'(e.zero));
    end
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("alu_idle", 32'({alu_rs1, alu_rs2, alu_carry_in, alu_op}), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] held_result;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({out_result, out_carry, out_zero}), 32'd0);
    check("rst_alu", 32'({alu_rs1, alu_rs2, alu_carry_in, alu_op}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(8'h5A, 8'h3C, 2'b00); wait_done(); handshake();
    start_op(8'hFF, 8'h01, 2'b00); wait_done(); handshake();
    start_op(8'h01, 8'h01, 2'b00); wait_done(); handshake();
    start_op(8'hAA, 8'hAA, 2'b01); wait_done(); handshake();
    start_op(8'hF0, 8'h3C, 2'b10); wait_done(); handshake();
    start_op(8'hF0, 8'h0F, 2'b11); wait_done(); handshake();

    // Slice stream ordering and carry chaining.
    start_op(8'h03, 8'h01, 2'b00); wait_done();
    check("rs1_seq", 32'(rs1_seq), 32'h03);
    check("rs2_seq", 32'(rs2_seq), 32'h01);
    check("cin_seq", 32'(cin_seq), 32'h06);
    handshake();

    // Back-pressure in DONE while new requests are offered.
    start_op(8'h12, 8'h34, 2'b00); wait_done();
    held_result = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_op = 2'b11;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'({out_result, out_carry, out_zero}), 32'({held_result, 1'b0, 1'b0}));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    @(posedge clk);
    #1;
    check("bp_no_accept", 32'(busy), 32'd0);
    check("idle_hold", 32'(out_result), 32'(held_result));

    // Asynchronous abort mid-SHIFT.
    start_op(8'h0F, 8'h01, 2'b00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_out_valid_hold", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h10, 8'h20, 2'b00); wait_done(); handshake();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
